// File: rtl/pic_fetch_unit.sv
// Fetch stage for the PIC16-style core: PC, instruction register and a
// circular return-address stack resolving GOTO/CALL/RETURN/RETLW/RETFIE.
module pic_fetch_unit #(
    parameter int STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] Rom_addr_out,
    input  logic [13:0] Rom_data_in,
    input  logic        stall,
    input  logic        skip_req,
    input  logic        branch_req,
    input  logic [10:0] branch_target,
    output logic [13:0] ir_out,
    output logic        ir_valid,
    output logic [10:0] ir_pc,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    localparam int SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int DW  = SPW + 1;
    localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

    typedef enum logic [1:0] {
        K_SEQ,
        K_JUMP,
        K_PUSH,
        K_POP
    } kind_t;

    logic [10:0]    pc;
    logic [10:0]    pc_inc;
    logic [10:0]    target;
    logic [10:0]    stack [STACK_DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_inc;
    logic [SPW-1:0] sp_dec;
    logic [DW-1:0]  depth;
    logic           is_goto;
    logic           is_call;
    logic           is_ret;
    logic           take_word;
    kind_t          kind;

    assign Rom_addr_out = pc;
    assign pc_inc       = pc + 11'd1;
    assign sp_inc       = sp + SPW'(1);
    assign sp_dec       = sp - SPW'(1);
    assign target       = Rom_data_in[10:0];

    assign is_goto = (Rom_data_in[13:11] == 3'b101);
    assign is_call = (Rom_data_in[13:11] == 3'b100);
    assign is_ret  = (Rom_data_in == 14'h0008)
                   || (Rom_data_in == 14'h0009)
                   || (Rom_data_in[13:10] == 4'b1101);

    // The fetched word only takes effect when execute is not redirecting us.
    assign take_word = !stall && !branch_req && !skip_req;

    always_comb begin
        kind = K_SEQ;
        unique case (1'b1)
            is_goto: kind = K_JUMP;
            is_call: kind = K_PUSH;
            is_ret:  kind = K_POP;
            default: kind = K_SEQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= 11'h000;
            ir_out          <= 14'h0000;
            ir_valid        <= 1'b0;
            ir_pc           <= 11'h000;
            sp              <= '0;
            depth           <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (!stall) begin
            if (branch_req) begin
                pc       <= branch_target;
                ir_out   <= 14'h0000;
                ir_valid <= 1'b0;
            end else if (skip_req) begin
                pc       <= pc_inc;
                ir_out   <= 14'h0000;
                ir_valid <= 1'b0;
            end else begin
                ir_out   <= Rom_data_in;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
                unique case (kind)
                    K_JUMP: pc <= target;
                    K_PUSH: begin
                        pc <= target;
                        sp <= sp_inc;
                        // A full stack overwrites its oldest entry.
                        if (depth == FULL) stack_overflow <= 1'b1;
                        else               depth <= depth + DW'(1);
                    end
                    K_POP: begin
                        pc <= stack[sp_dec];
                        sp <= sp_dec;
                        if (depth == '0) stack_underflow <= 1'b1;
                        else             depth <= depth - DW'(1);
                    end
                    default: pc <= pc_inc;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && take_word && kind == K_PUSH) begin
            stack[sp] <= pc_inc;
        end
    end

endmodule
